// File: rtl/imem_line_server.sv
// imem_line_server: memory-side responder for iCache line fills.
// A request is sampled, held for a fixed latency, and answered with a full
// line. The response is held until the iCache acks or drops its request.
// A back-door write port loads program lines.
// Optional build macro IMEM_STATS_EN adds fill and abort counters.
module imem_line_server #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 26,
    parameter int IDX_W   = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    input  logic              data_filled_ack,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic [LINE_W-1:0] data_to_fill,
    output logic              mem_data_rdy,
    output logic              busy
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]       req_count,
    output logic [15:0]       abort_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] mem [2**IDX_W];
    logic [LINE_W-1:0] rd_line;
    logic              fire, abort, complete;

    // Upper address bits alias onto the same line and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reqAddrI_mem[ADDR_W-1:IDX_W], wr_addr[ADDR_W-1:IDX_W]};

    // Abort wins over the final countdown cycle: a dropped request never gets a line.
    assign abort    = (state == WAIT) && !reqI_mem;
    assign fire     = (state == WAIT) && reqI_mem && (cnt == 8'd0);
    assign complete = (state == RESP) && (data_filled_ack || !reqI_mem);

    // Write-first: a back-door write to the index being read this cycle is forwarded.
    assign rd_line = (wr_en && (wr_addr[IDX_W-1:0] == idx_q)) ? wr_data : mem[idx_q];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (reqI_mem) state_nxt = WAIT;
            WAIT: if (abort) state_nxt = IDLE;
                  else if (fire) state_nxt = RESP;
            RESP: if (complete) state_nxt = DONE;
            DONE: if (!reqI_mem) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; the response flag is exactly "in RESP".
    always_comb begin
        mem_data_rdy = (state == RESP);
        busy         = (state != IDLE);
    end

    // Line array: no reset so program contents survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Latency counter, latched index and held response line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            idx_q        <= '0;
            data_to_fill <= '0;
        end else begin
            if (state == IDLE && reqI_mem) begin
                cnt   <= CNT_INIT;
                idx_q <= reqAddrI_mem[IDX_W-1:0];
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (fire) data_to_fill <= rd_line;
        end
    end

`ifdef IMEM_STATS_EN
    // Completed-fill and abort counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_count   <= '0;
            abort_count <= '0;
        end else begin
            if (complete) req_count   <= req_count + 32'd1;
            if (abort)    abort_count <= abort_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_line_server.sv
// Randomized scoreboard bench for imem_line_server.
// Driver issues line-fill transactions and pushes the expected line; a
// negedge monitor pops on each new response and checks the line is held.
module tb_imem_line_server;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         reqI_mem;
    logic [25:0]  reqAddrI_mem;
    logic         data_filled_ack;
    logic         wr_en;
    logic [25:0]  wr_addr;
    logic [127:0] wr_data;
    logic [127:0] data_to_fill;
    logic         mem_data_rdy;
    logic         busy;
`ifdef IMEM_STATS_EN
    logic [31:0]  req_count;
    logic [15:0]  abort_count;
`endif

    imem_line_server #(.LINE_W(128), .ADDR_W(26), .IDX_W(10), .LATENCY(L)) dut (
        .clk(clk), .reset(reset), .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .data_filled_ack(data_filled_ack), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .data_to_fill(data_to_fill), .mem_data_rdy(mem_data_rdy),
        .busy(busy)
`ifdef IMEM_STATS_EN
        , .req_count(req_count), .abort_count(abort_count)
`endif
    );

    always #5 clk = ~clk;

    int           nvec  = 0;
    int           nfail = 0;
    logic [127:0] mdl [16];
    logic [127:0] exp_q [$];
    int           m_fills  = 0;
    int           m_aborts = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: new response pops the scoreboard, held response must not change.
    logic         seen = 1'b0;
    logic [127:0] cur  = '0;
    always @(negedge clk) begin
        if (mem_data_rdy) begin
            if (!seen) begin
                seen = 1'b1;
                nvec++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_rdy: got data %h expected no response", data_to_fill);
                    cur = data_to_fill;
                end else begin
                    cur = exp_q.pop_front();
                    if (data_to_fill !== cur) begin
                        nfail++;
                        $display("FAIL fill_data: got %h expected %h", data_to_fill, cur);
                    end
                end
            end else begin
                nvec++;
                if (data_to_fill !== cur) begin
                    nfail++;
                    $display("FAIL held_data: got %h expected %h", data_to_fill, cur);
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [25:0] mkaddr(int idx);
        logic [25:0] a;
        a = 26'($urandom);
        a[9:0] = 10'(idx);
        return a;
    endfunction

    // Random back-door write, or a forced one to idx; model updated as it will land.
    task automatic rand_wr(bit force_same, int idx);
        int w;
        if (force_same || $urandom_range(0, 2) == 0) begin
            w = force_same ? idx : int'($urandom_range(0, 15));
            wr_en   = 1'b1;
            wr_addr = mkaddr(w);
            wr_data = rnd128();
            mdl[w]  = wr_data;
        end else begin
            wr_en = 1'b0;
        end
    endtask

    task automatic txn(int idx_in);
        int idx, abk, hold, extra;
        bit ab, use_ack;
        idx = (idx_in < 0) ? int'($urandom_range(0, 15)) : idx_in;
        ab  = (idx_in < 0) && ($urandom_range(0, 4) == 0);
        abk = int'($urandom_range(1, L - 1));
        reqI_mem = 1'b1;
        reqAddrI_mem = mkaddr(idx);
        rand_wr(1'b0, 0);
        step();
        chk("busy_wait", 128'(busy), 128'(1));
        for (int k = 1; k <= L; k++) begin
            reqAddrI_mem = 26'($urandom);
            if (ab && k == abk) begin
                reqI_mem = 1'b0;
                wr_en = 1'b0;
                step();
                m_aborts++;
                chk("busy_abort", 128'(busy), 128'(0));
                return;
            end
            rand_wr((k == L) && ($urandom_range(0, 1) == 1), idx);
            if (k == L) exp_q.push_back(mdl[idx]);
            step();
        end
        chk("rdy_latency", 128'(mem_data_rdy), 128'(1));
        hold = int'($urandom_range(0, 3));
        repeat (hold) begin
            rand_wr(1'b0, 0);
            step();
        end
        wr_en = 1'b0;
        use_ack = ($urandom_range(0, 1) == 1);
        if (use_ack) data_filled_ack = 1'b1;
        else         reqI_mem = 1'b0;
        step();
        m_fills++;
        data_filled_ack = 1'b0;
        chk("rdy_clear", 128'(mem_data_rdy), 128'(0));
        if (use_ack) begin
            extra = int'($urandom_range(0, 5));
            repeat (extra) begin
                step();
                chk("busy_done", 128'(busy), 128'(1));
            end
            reqI_mem = 1'b0;
        end
        step();
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    task automatic reset_txn();
        int idx, kk;
        idx = int'($urandom_range(0, 15));
        kk  = int'($urandom_range(1, L + 2));
        reqI_mem = 1'b1;
        reqAddrI_mem = mkaddr(idx);
        wr_en = 1'b0;
        step();
        for (int k = 1; k <= kk; k++) begin
            if (k == L) exp_q.push_back(mdl[idx]);
            step();
        end
        reset = 1'b0;
        reqI_mem = 1'b0;
        step();
        chk("rst_rdy", 128'(mem_data_rdy), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_data", data_to_fill, 128'(0));
        m_fills = 0;
        m_aborts = 0;
`ifdef IMEM_STATS_EN
        chk("rst_req_count", 128'(req_count), 128'(0));
        chk("rst_abort_count", 128'(abort_count), 128'(0));
`endif
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b0;
        reqI_mem = 1'b0;
        reqAddrI_mem = '0;
        data_filled_ack = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        step();
        step();
        chk("init_rdy", 128'(mem_data_rdy), 128'(0));
        chk("init_busy", 128'(busy), 128'(0));
        chk("init_data", data_to_fill, 128'(0));
        reset = 1'b1;
        // Preload lines 0..15 so every reachable index has known contents.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_addr = mkaddr(i);
            wr_data = rnd128();
            mdl[i] = wr_data;
            step();
        end
        wr_en = 1'b1;
        wr_addr = 26'h3;
        wr_data = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        mdl[3] = wr_data;
        step();
        wr_en = 1'b0;
        txn(3);
        txn(3);
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 7) == 0) reset_txn();
            else                           txn(-1);
        end
        txn(3);
        repeat (3) step();
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
`ifdef IMEM_STATS_EN
        chk("req_count", 128'(req_count), 128'(m_fills));
        chk("abort_count", 128'(abort_count), 128'(m_aborts));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
